// File: rtl/apb_master_ctrl_if.sv
// Command/response and APB bus bundle for apb_master_ctrl.
// master: the requester's view; slave: the bench/consumer's view.
interface apb_master_ctrl_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_error;
   logic              rsp_timeout;
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic              PREADY;
   logic [DATA_W-1:0] PRDATA;
   logic              PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  PREADY, PRDATA, PSLVERR,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output PREADY, PRDATA, PSLVERR,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB requester: one command -> one IDLE/SETUP/ACCESS transfer, 1-cycle response.
// Optional ACCESS watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_ctrl #(
   parameter int ADDR_W         = 5,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              CLK,
   input  logic              Rst,
   apb_master_ctrl_if.master bus,
   output logic [1:0]        P_stsMST
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } state_t;

   state_t state, nxt;
   logic   accept, done, abort;

   assign done   = (state == ACCESS) && bus.PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CW-1:0] cnt;

   // PREADY on the last allowed cycle still completes normally
   assign abort = (state == ACCESS) && !bus.PREADY &&
                  (cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK) begin
      if (Rst)
         cnt <= '0;
      else if (state == SETUP)
         cnt <= '0;
      else if (state == ACCESS && !bus.PREADY)
         cnt <= cnt + 1'b1;
   end
`else
   logic unused_to;
   assign unused_to = (TIMEOUT_CYCLES != 0);
   assign abort     = 1'b0;
`endif

   assign bus.cmd_ready = (state == IDLE) || (done && !abort);
   assign accept        = bus.cmd_valid && bus.cmd_ready;
   assign P_stsMST      = state;

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (accept) nxt = SETUP;
         SETUP:   nxt = ACCESS;
         ACCESS: begin
            if (done)
               nxt = accept ? SETUP : IDLE;
            else if (abort)
               nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Rst) begin
         state           <= IDLE;
         bus.PSEL        <= 1'b0;
         bus.PENABLE     <= 1'b0;
         bus.PWRITE      <= 1'b0;
         bus.PADDR       <= '0;
         bus.PWDATA      <= '0;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_rdata   <= '0;
         bus.rsp_error   <= 1'b0;
         bus.rsp_timeout <= 1'b0;
      end else begin
         state       <= nxt;
         bus.PSEL    <= (nxt != IDLE);
         bus.PENABLE <= (nxt == ACCESS);
         if (accept) begin
            bus.PWRITE <= bus.cmd_write;
            bus.PADDR  <= bus.cmd_addr;
            bus.PWDATA <= bus.cmd_write ? bus.cmd_wdata : '0;
         end
         bus.rsp_valid   <= done || abort;
         bus.rsp_rdata   <= (done && !bus.PWRITE) ? bus.PRDATA : '0;
         bus.rsp_error   <= done ? bus.PSLVERR : abort;
         bus.rsp_timeout <= abort;
      end
   end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: 32x8 slave model, reference memory,
// directed steps plus randomized transfers.
module tb_apb_master_ctrl;

   logic       CLK = 1'b0;
   logic       Rst = 1'b1;
   logic       sclr = 1'b1;
   logic [1:0] sts;
   int         passed = 0;
   int         fails = 0;
   int         total = 0;
   logic [7:0] smem    [32];
   logic [7:0] ref_mem [32];

   apb_master_ctrl_if #(.ADDR_W(5), .DATA_W(8)) bus ();

   apb_master_ctrl #(
      .ADDR_W(5), .DATA_W(8), .TIMEOUT_CYCLES(16)
   ) dut (
      .CLK      (CLK),
      .Rst      (Rst),
      .bus      (bus),
      .P_stsMST (sts)
   );

   always #5 CLK = ~CLK;

   // slave: combinational read, write on completion unless it signals an error
   always_comb bus.PRDATA = smem[bus.PADDR];

   always @(posedge CLK) begin
      if (sclr) begin
         for (int i = 0; i < 32; i++) smem[i] <= 8'((i * 37) + 11);
      end else if (bus.PSEL && bus.PENABLE && bus.PREADY &&
                   bus.PWRITE && !bus.PSLVERR) begin
         smem[bus.PADDR] <= bus.PWDATA;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input bit w, input logic [4:0] a,
                       input logic [7:0] d, input int waits, input bit err);
      logic [7:0] exp_rd;
      logic [7:0] exp_wd;
      exp_rd = w ? 8'h00 : ref_mem[a];
      exp_wd = w ? d : 8'h00;
      if (w && !err) ref_mem[a] = d;
      @(negedge CLK);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      bus.PREADY    = 1'b0;
      bus.PSLVERR   = 1'b0;
      chk("ready_idle", 32'(bus.cmd_ready), 1);
      @(negedge CLK);
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = ~a;
      bus.cmd_wdata = ~d;
      chk("setup_sts", 32'(sts), 1);
      chk("setup_selen", 32'({bus.PSEL, bus.PENABLE}), 2);
      chk("setup_addr", 32'(bus.PADDR), 32'(a));
      chk("setup_write", 32'(bus.PWRITE), 32'(w));
      chk("setup_wdata", 32'(bus.PWDATA), 32'(exp_wd));
      chk("setup_ready", 32'(bus.cmd_ready), 0);
      for (int i = 0; i <= waits; i++) begin
         @(negedge CLK);
         bus.PREADY  = (i == waits);
         // PSLVERR noise during wait states must be ignored
         bus.PSLVERR = (i == waits) ? err : 1'($urandom_range(0, 1));
         chk("acc_sts", 32'(sts), 2);
         chk("acc_selen", 32'({bus.PSEL, bus.PENABLE}), 3);
         chk("acc_addr", 32'(bus.PADDR), 32'(a));
         chk("acc_wdata", 32'(bus.PWDATA), 32'(exp_wd));
         chk("acc_norsp", 32'(bus.rsp_valid), 0);
      end
      @(negedge CLK);
      bus.PREADY  = 1'b0;
      bus.PSLVERR = 1'b0;
      chk("rsp_valid", 32'(bus.rsp_valid), 1);
      chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
      chk("rsp_error", 32'(bus.rsp_error), 32'(err));
      chk("rsp_timeout", 32'(bus.rsp_timeout), 0);
      chk("rsp_sts", 32'(sts), 0);
      chk("rsp_psel", 32'(bus.PSEL), 0);
      @(negedge CLK);
      chk("rsp_pulse", 32'(bus.rsp_valid), 0);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.PREADY    = 1'b0;
      bus.PSLVERR   = 1'b0;
      for (int i = 0; i < 32; i++) ref_mem[i] = 8'((i * 37) + 11);

      // reset state
      repeat (3) @(negedge CLK);
      chk("rst_sts", 32'(sts), 0);
      chk("rst_bus", 32'({bus.PSEL, bus.PENABLE, bus.PWRITE}), 0);
      chk("rst_addr", 32'(bus.PADDR), 0);
      chk("rst_wdata", 32'(bus.PWDATA), 0);
      chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_error, bus.rsp_timeout}), 0);
      chk("rst_rdata", 32'(bus.rsp_rdata), 0);
      Rst  = 1'b0;
      sclr = 1'b0;
      chk("rst_ready", 32'(bus.cmd_ready), 1);

      // write then read back with two wait states
      xfer(1'b1, 5'h03, 8'hA5, 0, 1'b0);
      xfer(1'b0, 5'h03, 8'h00, 2, 1'b0);

      // back-to-back write/read of 5'h1F
      ref_mem[31] = 8'h5A;
      @(negedge CLK);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 5'h1F;
      bus.cmd_wdata = 8'h5A;
      bus.PREADY    = 1'b1;
      chk("b2b_ready0", 32'(bus.cmd_ready), 1);
      @(negedge CLK);
      chk("b2b_selen0", 32'({bus.PSEL, bus.PENABLE}), 2);
      chk("b2b_ready1", 32'(bus.cmd_ready), 0);
      bus.cmd_write = 1'b0;
      @(negedge CLK);
      chk("b2b_selen1", 32'({bus.PSEL, bus.PENABLE}), 3);
      chk("b2b_ready2", 32'(bus.cmd_ready), 1);
      @(negedge CLK);
      bus.cmd_valid = 1'b0;
      chk("b2b_selen2", 32'({bus.PSEL, bus.PENABLE}), 2);
      chk("b2b_addr", 32'(bus.PADDR), 32'h1F);
      chk("b2b_write", 32'(bus.PWRITE), 0);
      chk("b2b_rsp1", 32'({bus.rsp_valid, bus.rsp_error}), 2);
      chk("b2b_rdata1", 32'(bus.rsp_rdata), 0);
      @(negedge CLK);
      chk("b2b_selen3", 32'({bus.PSEL, bus.PENABLE}), 3);
      chk("b2b_gap", 32'(bus.rsp_valid), 0);
      @(negedge CLK);
      bus.PREADY = 1'b0;
      chk("b2b_rsp2", 32'({bus.rsp_valid, bus.rsp_error}), 2);
      chk("b2b_rdata2", 32'(bus.rsp_rdata), 32'h5A);
      chk("b2b_idle", 32'(sts), 0);

      // slave error on a read
      xfer(1'b0, 5'h10, 8'h00, 0, 1'b1);

      // completion on the last allowed wait cycle
      xfer(1'b0, 5'h03, 8'h00, 15, 1'b0);

      // reset while stalled in ACCESS
      @(negedge CLK);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 5'h10;
      bus.cmd_wdata = 8'hC3;
      @(negedge CLK);
      bus.cmd_valid = 1'b0;
      @(negedge CLK);
      chk("mrst_acc", 32'(sts), 2);
      Rst = 1'b1;
      @(negedge CLK);
      chk("mrst_sts", 32'(sts), 0);
      chk("mrst_bus", 32'({bus.PSEL, bus.PENABLE, bus.PWRITE}), 0);
      chk("mrst_addr", 32'(bus.PADDR), 0);
      chk("mrst_wdata", 32'(bus.PWDATA), 0);
      chk("mrst_rsp", 32'(bus.rsp_valid), 0);
      Rst = 1'b0;
      chk("mrst_ready", 32'(bus.cmd_ready), 1);
      @(negedge CLK);
      chk("mrst_norsp", 32'(bus.rsp_valid), 0);

`ifdef APB_MASTER_TIMEOUT_EN
      // watchdog abort after 16 stalled ACCESS cycles
      @(negedge CLK);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 5'h07;
      bus.PREADY    = 1'b0;
      @(negedge CLK);
      bus.cmd_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         chk("to_acc", 32'(sts), 2);
         chk("to_norsp", 32'(bus.rsp_valid), 0);
      end
      @(negedge CLK);
      chk("to_rsp", 32'({bus.rsp_valid, bus.rsp_error, bus.rsp_timeout}), 7);
      chk("to_rdata", 32'(bus.rsp_rdata), 0);
      chk("to_idle", 32'(sts), 0);
      chk("to_psel", 32'({bus.PSEL, bus.PENABLE}), 0);
      @(negedge CLK);
      chk("to_pulse", 32'(bus.rsp_valid), 0);
`else
      // without the watchdog a long stall still completes
      xfer(1'b0, 5'h07, 8'h00, 20, 1'b0);
`endif

      // randomized transfers
      for (int k = 0; k < 40; k++) begin
         xfer(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              8'($urandom_range(0, 255)), $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
